// File: rtl/echo_capture_if.sv
// Readout stream interface for echo_capture: valid/ready beats of captured ADC samples.
// The master drives data and valid/last, the slave drives ready.
interface echo_capture_if #(
  parameter int ADC_W = 8
) ();
  logic             rd_valid;
  logic             rd_ready;
  logic [ADC_W-1:0] rd_data;
  logic             rd_last;

  modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/echo_capture.sv
// Trigger-synchronised echo capture: blanking delay, window capture into RAM, valid/ready readout.
// Optional peak detector (max sample and its first index) enabled by defining ECHO_PEAK_DET_EN.
module echo_capture #(
  parameter int ADC_W      = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int DELAY_W    = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_trig_in,
  input  logic [DELAY_W-1:0]    i_delay,
  input  logic [DEPTH_LOG2:0]   i_length,
  input  logic [ADC_W-1:0]      i_adc_data,
  output logic                  o_busy,
  output logic                  o_missed_trig,
`ifdef ECHO_PEAK_DET_EN
  output logic [ADC_W-1:0]      o_peak_val,
  output logic [DEPTH_LOG2-1:0] o_peak_idx,
`endif
  echo_capture_if.master        rd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEN_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] LEN_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DELAY_W-1:0]  DLY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_READOUT
  } state_t;

  state_t              r_state;
  logic                r_trig_d;
  logic                r_busy;
  logic                r_missed;
  logic [DEPTH_LOG2:0] r_len;
  logic [DELAY_W-1:0]  r_delay;
  logic [DELAY_W-1:0]  r_dcnt;
  logic [DEPTH_LOG2:0] r_wcnt;
  logic [DEPTH_LOG2:0] r_raddr;
  logic [DEPTH_LOG2:0] r_beat;
  logic                r_q_valid;
  logic [ADC_W-1:0]    r_ram_q;
  logic                r_rd_valid;
  logic [ADC_W-1:0]    r_rd_data;
  logic                r_rd_last;
  logic [ADC_W-1:0]    r_mem [DEPTH];

  logic                w_trig_rise;
  logic                w_wr_en;
  logic                w_last_wr;
  logic                w_out_load;
  logic                w_rd_issue;
  logic                w_move;
  logic                w_last_xfer;
  logic [DEPTH_LOG2:0] w_len_clamped;

  // Zero-length windows still capture one sample; oversize windows fill the whole buffer.
  always_comb begin
    w_len_clamped = i_length;
    if (i_length == '0)
      w_len_clamped = LEN_ONE;
    else if (i_length > LEN_MAX)
      w_len_clamped = LEN_MAX;
  end

  assign w_trig_rise = i_trig_in & ~r_trig_d;
  assign w_wr_en     = i_en && (r_state == S_CAPTURE);
  assign w_last_wr   = (r_wcnt == r_len - LEN_ONE);

  // Two-stage readout: RAM output register feeds the output register, so a read issued
  // one cycle ahead keeps rd_valid continuous under a constant rd_ready.
  assign w_out_load  = ~r_rd_valid | rd.rd_ready;
  assign w_rd_issue  = i_en && (r_state == S_READOUT) && (r_raddr < r_len) &&
                       (~r_q_valid | w_out_load);
  assign w_move      = r_q_valid & w_out_load;
  assign w_last_xfer = (r_state == S_READOUT) & r_rd_valid & rd.rd_ready & r_rd_last;

  // NOTE: the sample buffer has no reset so it maps onto block RAM; contents are only
  // ever read after being written in the same window.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wcnt[DEPTH_LOG2-1:0]] <= i_adc_data;
    if (w_rd_issue)
      r_ram_q <= r_mem[r_raddr[DEPTH_LOG2-1:0]];
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_trig_d   <= 1'b0;
      r_busy     <= 1'b0;
      r_missed   <= 1'b0;
      r_len      <= '0;
      r_delay    <= '0;
      r_dcnt     <= '0;
      r_wcnt     <= '0;
      r_raddr    <= '0;
      r_beat     <= '0;
      r_q_valid  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_trig_d <= i_trig_in;
      if (!i_en) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_missed   <= 1'b0;
        r_dcnt     <= '0;
        r_wcnt     <= '0;
        r_q_valid  <= 1'b0;
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end else begin
        if (w_trig_rise && (r_state inside {S_DELAY, S_CAPTURE, S_READOUT}))
          r_missed <= 1'b1;
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARMED;
            r_len   <= w_len_clamped;
            r_delay <= i_delay;
          end
          S_ARMED: begin
            if (w_trig_rise) begin
              r_wcnt <= '0;
              r_busy <= 1'b1;
              if (r_delay != '0) begin
                r_state <= S_DELAY;
                r_dcnt  <= r_delay;
              end else begin
                r_state <= S_CAPTURE;
              end
            end
          end
          S_DELAY: begin
            if (r_dcnt == DLY_ONE)
              r_state <= S_CAPTURE;
            else
              r_dcnt <= r_dcnt - DLY_ONE;
          end
          S_CAPTURE: begin
            r_wcnt <= r_wcnt + LEN_ONE;
            if (w_last_wr) begin
              r_state    <= S_READOUT;
              r_busy     <= 1'b0;
              r_raddr    <= '0;
              r_beat     <= '0;
              r_q_valid  <= 1'b0;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
            end
          end
          S_READOUT: begin
            if (w_rd_issue)
              r_raddr <= r_raddr + LEN_ONE;
            r_q_valid <= w_rd_issue | (r_q_valid & ~w_out_load);
            if (w_move) begin
              r_rd_data  <= r_ram_q;
              r_rd_valid <= 1'b1;
              r_rd_last  <= (r_beat == r_len - LEN_ONE);
              r_beat     <= r_beat + LEN_ONE;
            end else if (r_rd_valid && rd.rd_ready) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
            end
            if (w_last_xfer) begin
              r_state <= S_ARMED;
              r_len   <= w_len_clamped;
              r_delay <= i_delay;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Dropping en kills the visible status in the same cycle; the registers follow next edge.
  assign o_busy        = r_busy & i_en;
  assign o_missed_trig = r_missed & i_en;
  assign rd.rd_valid   = r_rd_valid & i_en;
  assign rd.rd_data    = r_rd_data;
  assign rd.rd_last    = r_rd_last & i_en;

`ifdef ECHO_PEAK_DET_EN
  logic [ADC_W-1:0]      r_pk_val;
  logic [DEPTH_LOG2-1:0] r_pk_idx;
  logic [ADC_W-1:0]      r_peak_val;
  logic [DEPTH_LOG2-1:0] r_peak_idx;
  logic                  w_pk_take;

  // Strict greater-than keeps the first occurrence of the maximum.
  assign w_pk_take = (r_wcnt == '0) || (i_adc_data > r_pk_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pk_val   <= '0;
      r_pk_idx   <= '0;
      r_peak_val <= '0;
      r_peak_idx <= '0;
    end else if (w_wr_en) begin
      if (w_pk_take) begin
        r_pk_val <= i_adc_data;
        r_pk_idx <= r_wcnt[DEPTH_LOG2-1:0];
      end
      if (w_last_wr) begin
        r_peak_val <= w_pk_take ? i_adc_data : r_pk_val;
        r_peak_idx <= w_pk_take ? r_wcnt[DEPTH_LOG2-1:0] : r_pk_idx;
      end
    end
  end

  assign o_peak_val = r_peak_val;
  assign o_peak_idx = r_peak_idx;
`endif

endmodule

// File: tb/tb_echo_capture.sv
// Randomised bench for echo_capture: ADC history + trigger time predict each readout window.
module tb_echo_capture;
  localparam int ADC_W = 8;
  localparam int DL2   = 10;
  localparam int DW    = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              trig = 1'b0;
  logic [DW-1:0]     delay = '0;
  logic [DL2:0]      length = '0;
  logic [ADC_W-1:0]  adc = '0;
  logic              busy;
  logic              missed;
`ifdef ECHO_PEAK_DET_EN
  logic [ADC_W-1:0]  peak_val;
  logic [DL2-1:0]    peak_idx;
`endif

  echo_capture_if #(.ADC_W(ADC_W)) rd_if ();

  echo_capture #(.ADC_W(ADC_W), .DEPTH_LOG2(DL2), .DELAY_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (en),
    .i_trig_in     (trig),
    .i_delay       (delay),
    .i_length      (length),
    .i_adc_data    (adc),
    .o_busy        (busy),
    .o_missed_trig (missed),
`ifdef ECHO_PEAK_DET_EN
    .o_peak_val    (peak_val),
    .o_peak_idx    (peak_idx),
`endif
    .rd            (rd_if.master)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [ADC_W-1:0] hist [int];
  int  ready_mode = 0;
  bit  pk_force = 1'b0;
  int  pk_base = -100;

  logic [ADC_W-1:0] got_d [$];
  bit               got_l [$];
  bit               mon_on = 1'b0;
  bit               ro_active = 1'b0;
  bit               stall_prev = 1'b0;
  logic [ADC_W-1:0] stall_data = '0;
  int               busy_cnt = 0;
  int               gaps = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle ADC stimulus and ready pattern; hist[k] is the sample present during cycle k.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (pk_force && (cyc == pk_base + 7 || cyc == pk_base + 9))
      adc = 8'hF0;
    else if (pk_force)
      adc = 8'($urandom_range(0, 239));
    else
      adc = 8'($urandom);
    hist[cyc] = adc;
    case (ready_mode)
      0:       rd_if.rd_ready = 1'b1;
      1:       rd_if.rd_ready = ~rd_if.rd_ready;
      default: rd_if.rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (mon_on) begin
      if (stall_prev)
        check("hold_while_stalled", {31'd0, rd_if.rd_valid} << 8 | 32'(rd_if.rd_data),
              32'h100 | 32'(stall_data));
      stall_prev = rd_if.rd_valid && !rd_if.rd_ready;
      if (stall_prev) stall_data = rd_if.rd_data;
      if (ro_active && !rd_if.rd_valid) gaps++;
      if (rd_if.rd_valid) ro_active = !(rd_if.rd_ready && rd_if.rd_last);
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        got_d.push_back(rd_if.rd_data);
        got_l.push_back(rd_if.rd_last);
      end
    end
  end

  task automatic run_window(input int d, input int len, input int rmode, input int extra);
    int eff, t, n, budget, mx, mi;
    ready_mode = rmode;
    delay  = DW'(d);
    length = (DL2+1)'(len);
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (3) step();
    eff = (len == 0) ? 1 : ((len > (1 << DL2)) ? (1 << DL2) : len);
    got_d.delete();
    got_l.delete();
    busy_cnt = 0;
    gaps = 0;
    ro_active = 1'b0;
    stall_prev = 1'b0;
    mon_on = 1'b1;
    trig = 1'b1;
    t = cyc;
    pk_base = t + d + 1;
    step();
    trig = 1'b0;
    if (extra > 0) begin
      repeat (extra - 1) step();
      trig = 1'b1;
      step();
      trig = 1'b0;
    end
    budget = d + 4 * eff + 100;
    n = 0;
    while (!(got_l.size() > 0 && got_l[got_l.size()-1]) && n < budget) begin
      step();
      n++;
    end
    check("window_timeout", 32'(n < budget), 32'd1);
    step();
    mon_on = 1'b0;
    check("beat_count", got_d.size(), eff);
    for (int i = 0; i < got_d.size() && i < eff; i++) begin
      check($sformatf("data[%0d]", i), 32'(got_d[i]), 32'(hist[t + d + 1 + i]));
      check($sformatf("last[%0d]", i), 32'(got_l[i]), 32'(i == eff - 1));
    end
    check("busy_cycles", busy_cnt, d + eff);
    if (rmode == 0) check("valid_gaps", gaps, 0);
    check("missed_trig", 32'(missed), 32'(extra > 0));
`ifdef ECHO_PEAK_DET_EN
    mx = -1;
    mi = 0;
    for (int i = 0; i < eff; i++)
      if (int'(hist[t + d + 1 + i]) > mx) begin
        mx = int'(hist[t + d + 1 + i]);
        mi = i;
      end
    check("peak_val", 32'(peak_val), mx);
    check("peak_idx", 32'(peak_idx), mi);
`else
    mx = 0;
    mi = 0;
`endif
  endtask

  initial begin
    rd_if.rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_missed", 32'(missed), 0);
    check("rst_valid", 32'(rd_if.rd_valid), 0);
    check("rst_last", 32'(rd_if.rd_last), 0);
    check("rst_data", 32'(rd_if.rd_data), 0);
    rst_n = 1'b1;
    step();

    run_window(0, 4, 0, 0);
    run_window(100, 16, 0, 0);
    run_window(0, 8, 1, 0);
    run_window(0, 32, 0, 5);

    // missed_trig clears while en is low and stays clear after re-enable
    en = 1'b0;
    @(negedge clk);
    check("missed_clear_en_low", 32'(missed), 0);
    step();
    en = 1'b1;
    @(negedge clk);
    check("missed_after_reenable", 32'(missed), 0);
    step();

    // en dropped mid-capture: window is abandoned, nothing is read out
    ready_mode = 0;
    delay = '0;
    length = 11'd64;
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (3) step();
    trig = 1'b1;
    step();
    trig = 1'b0;
    repeat (10) step();
    got_d.delete();
    got_l.delete();
    mon_on = 1'b1;
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(rd_if.rd_valid), 0);
    step();
    en = 1'b1;
    busy_cnt = 0;
    repeat (100) step();
    mon_on = 1'b0;
    check("abort_no_beats", got_d.size(), 0);
    check("abort_no_busy", busy_cnt, 0);
    run_window(0, 20, 2, 0);

    run_window(3, 0, 0, 0);
    run_window(0, 2000, 0, 0);

    pk_force = 1'b1;
    run_window(5, 16, 2, 0);
    pk_force = 1'b0;
`ifdef ECHO_PEAK_DET_EN
    check("peak_f0_val", 32'(peak_val), 32'hF0);
    check("peak_f0_idx", 32'(peak_idx), 7);
`endif

    for (int k = 0; k < 6; k++)
      run_window(int'($urandom_range(0, 200)), int'($urandom_range(0, 100)), 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
